// File: rtl/pc_gen_ras_if.sv
// rtl/pc_gen_ras_if.sv - fetch pc generator control/status bundle
interface pc_gen_ras_if #(
   parameter int ADDR_W    = 15,
   parameter int RAS_DEPTH = 4
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic              hcf;
   logic              stall;
   logic [1:0]        pc_sel;
   logic [ADDR_W-1:0] predict_target_pc;
   logic [ADDR_W-1:0] exe_pc;
   logic [ADDR_W-1:0] exe_target_pc;
   logic              if_rvc;
   logic              if_call;
   logic              if_ret;
   logic              ras_clear;
   logic              imem_ready;

   logic [ADDR_W-1:0] pc;
   logic              imem_req_valid;
   logic [1:0]        pc_src;
   logic              halted;
   logic              ras_empty;
   logic [CNT_W-1:0]  ras_count;

   modport master (
      output hcf, stall, pc_sel, predict_target_pc, exe_pc, exe_target_pc,
             if_rvc, if_call, if_ret, ras_clear, imem_ready,
      input  pc, imem_req_valid, pc_src, halted, ras_empty, ras_count
   );

   modport slave (
      input  hcf, stall, pc_sel, predict_target_pc, exe_pc, exe_target_pc,
             if_rvc, if_call, if_ret, ras_clear, imem_ready,
      output pc, imem_req_valid, pc_src, halted, ras_empty, ras_count
   );
endinterface

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - IF-stage pc generator with sticky halt and circular return-address stack
module pc_gen_ras #(
   parameter int                ADDR_W    = 15,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                RAS_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   pc_gen_ras_if.slave  bus
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]        src_q, src_d;
   logic              halted_q;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [ADDR_W-1:0] seq, exe_seq, ras_top;
   logic [PTR_W-1:0]  top_idx, mem_waddr;
   logic              mem_we, accept, ras_nonempty;

   assign seq          = pc_q + (bus.if_rvc ? ADDR_W'(2) : ADDR_W'(4));
   assign exe_seq      = bus.exe_pc + ADDR_W'(4);
   assign top_idx      = ptr_q - PTR_W'(1);
   assign ras_top      = ras_mem[top_idx];
   assign ras_nonempty = (cnt_q != '0);
   // imem_req_valid already carries ~halted, so accept implies not halted
   assign accept       = ~halted_q & bus.imem_ready & ~bus.stall & ~bus.pc_sel[1];

   assign bus.pc             = pc_q;
   assign bus.pc_src         = src_q;
   assign bus.halted         = halted_q;
   assign bus.imem_req_valid = ~halted_q;
   assign bus.ras_count      = cnt_q;
   assign bus.ras_empty      = ~ras_nonempty;

   // Next pc selection: halt, EXE redirects, stall/backpressure, predictor, RAS, sequential
   always_comb begin
      pc_d  = pc_q;
      src_d = src_q;
      if (halted_q || bus.hcf) begin
         pc_d  = pc_q;
         src_d = src_q;
      end else if (bus.pc_sel == 2'd3) begin
         pc_d  = bus.exe_target_pc;
         src_d = 2'd3;
      end else if (bus.pc_sel == 2'd2) begin
         pc_d  = exe_seq;
         src_d = 2'd3;
      end else if (bus.stall || !bus.imem_ready) begin
         pc_d  = pc_q;
         src_d = src_q;
      end else if (bus.pc_sel == 2'd1) begin
         pc_d  = bus.predict_target_pc;
         src_d = 2'd1;
      end else if (bus.if_ret && ras_nonempty) begin
         pc_d  = ras_top;
         src_d = 2'd2;
      end else begin
         pc_d  = seq;
         src_d = 2'd0;
      end
   end

   // RAS bookkeeping: flush wins, otherwise push/pop/replace on an accepted fetch
   always_comb begin
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      if (bus.ras_clear) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (bus.if_call && bus.if_ret && ras_nonempty) begin
            mem_we    = 1'b1;
            mem_waddr = top_idx;
         end else if (bus.if_call) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
         end else if (bus.if_ret && ras_nonempty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // pc, source tag, halt flag and RAS pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         src_q    <= 2'd0;
         halted_q <= 1'b0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         pc_q  <= pc_d;
         src_q <= src_d;
         if (bus.hcf) halted_q <= 1'b1;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // RAS storage; contents are don't-care after reset so no reset term
   always_ff @(posedge clk) begin
      if (mem_we) ras_mem[mem_waddr] <= seq;
   end
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb/tb_pc_gen_ras.sv - directed and randomized checks of pc_gen_ras against a queue-based model
module tb_pc_gen_ras;
   localparam int ADDR_W = 15;
   localparam int DEPTH  = 4;
   localparam int RST_PC = 'h100;
   localparam int MASK   = (1 << ADDR_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors  = 0;

   int   m_pc, m_src, m_halted;
   int   q[$];

   pc_gen_ras_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH)) bus ();

   pc_gen_ras #(.ADDR_W(ADDR_W), .RESET_PC(15'h100), .RAS_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_src = 0; m_halted = 0;
      q.delete();
   endtask

   // Evaluate the spec rules on the inputs currently driven, before the edge
   task automatic model_step();
      int seq, acc, ret_ok;
      seq    = (m_pc + (bus.if_rvc ? 2 : 4)) & MASK;
      acc    = (m_halted == 0) && bus.imem_ready && !bus.stall && (bus.pc_sel < 2);
      ret_ok = bus.if_ret && (q.size() > 0);
      if (m_halted != 0 || bus.hcf) begin
         m_halted = 1;
      end else if (bus.pc_sel == 3) begin
         m_pc = int'(bus.exe_target_pc); m_src = 3;
      end else if (bus.pc_sel == 2) begin
         m_pc = (int'(bus.exe_pc) + 4) & MASK; m_src = 3;
      end else if (bus.stall || !bus.imem_ready) begin
      end else if (bus.pc_sel == 1) begin
         m_pc = int'(bus.predict_target_pc); m_src = 1;
      end else if (ret_ok) begin
         m_pc = q[$]; m_src = 2;
      end else begin
         m_pc = seq; m_src = 0;
      end
      if (bus.ras_clear) begin
         q.delete();
      end else if (acc) begin
         if (bus.if_call && ret_ok) q[q.size()-1] = seq;
         else if (bus.if_call) begin
            q.push_back(seq);
            if (q.size() > DEPTH) void'(q.pop_front());
         end else if (ret_ok) void'(q.pop_back());
      end
   endtask

   task automatic check_all();
      chk("pc", bus.pc, m_pc);
      chk("pc_src", bus.pc_src, m_src);
      chk("halted", bus.halted, m_halted);
      chk("imem_req_valid", bus.imem_req_valid, (m_halted == 0));
      chk("ras_count", bus.ras_count, q.size());
      chk("ras_empty", bus.ras_empty, (q.size() == 0));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      bus.hcf = 0; bus.stall = 0; bus.pc_sel = 0;
      bus.predict_target_pc = '0; bus.exe_pc = '0; bus.exe_target_pc = '0;
      bus.if_rvc = 0; bus.if_call = 0; bus.if_ret = 0; bus.ras_clear = 0;
      bus.imem_ready = 1;
   endtask

   task automatic redirect(input int tgt);
      idle(); bus.pc_sel = 3; bus.exe_target_pc = ADDR_W'(tgt);
      cycle();
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      check_all();
      chk("reset_pc", bus.pc, 'h100);

      // sequential steps with alternating width
      bus.if_rvc = 0; cycle(); chk("seq4", bus.pc, 'h104);
      bus.if_rvc = 1; cycle(); chk("seq2", bus.pc, 'h106);
      bus.if_rvc = 0; cycle(); chk("seq4b", bus.pc, 'h10A);

      // stall hold, then EXE redirect overrides stall
      redirect('h200);
      bus.stall = 1;
      repeat (3) begin cycle(); chk("stall_hold", bus.pc, 'h200); end
      bus.pc_sel = 3; bus.exe_target_pc = 15'h40;
      cycle(); chk("exe_over_stall", bus.pc, 'h40); chk("exe_src", bus.pc_src, 3);
      idle();

      // nested calls and returns
      redirect('h10);
      bus.if_call = 1; cycle(); idle();
      redirect('h80);
      bus.if_call = 1; bus.if_rvc = 1; cycle(); idle();
      chk("ras_two", bus.ras_count, 2);
      bus.if_ret = 1; cycle(); chk("ret1", bus.pc, 'h82); chk("ret1_src", bus.pc_src, 2);
      cycle(); chk("ret2", bus.pc, 'h14);
      cycle(); chk("ret3_seq", bus.pc, 'h18); chk("ret3_empty", bus.ras_empty, 1);
      idle();

      // overflow: five pushes into four entries, oldest lost
      redirect('h300);
      bus.if_call = 1;
      repeat (5) cycle();
      chk("ras_full", bus.ras_count, DEPTH);
      idle(); bus.if_ret = 1;
      repeat (5) cycle();
      chk("ras_drained", bus.ras_empty, 1);
      idle();

      // address wrap
      redirect('h7FFE);
      cycle(); chk("wrap", bus.pc, 'h0002);

      // async reset mid-stream
      bus.if_call = 1; cycle(); idle();
      #2 rst = 1;
      #1;
      chk("arst_pc", bus.pc, 'h100);
      chk("arst_ras", bus.ras_count, 0);
      model_reset();
      @(posedge clk); #1; rst = 0;
      check_all();

      // halt together with EXE redirect
      redirect('h30);
      bus.hcf = 1; bus.pc_sel = 3; bus.exe_target_pc = 15'h999;
      cycle(); chk("halt_pc", bus.pc, 'h30); chk("halt_flag", bus.halted, 1);
      idle(); bus.if_call = 1;
      repeat (4) cycle();
      chk("halt_ras", bus.ras_count, 0); chk("halt_req", bus.imem_req_valid, 0);
      idle();
      rst = 1; #1;
      chk("rst_clears_halt", bus.halted, 0);
      model_reset();
      @(posedge clk); #1; rst = 0;
      check_all();

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         bus.hcf               = 0;
         bus.stall             = ($urandom_range(0, 3) == 0);
         bus.imem_ready        = ($urandom_range(0, 3) != 0);
         bus.pc_sel            = ($urandom_range(0, 7) < 5) ? 2'd0 : 2'($urandom_range(1, 3));
         bus.predict_target_pc = ADDR_W'($urandom);
         bus.exe_pc            = ADDR_W'($urandom);
         bus.exe_target_pc     = ADDR_W'($urandom);
         bus.if_rvc            = 1'($urandom);
         bus.if_call           = ($urandom_range(0, 2) == 0);
         bus.if_ret            = ($urandom_range(0, 2) == 0);
         bus.ras_clear         = ($urandom_range(0, 31) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
Parametrised fetch program-counter generator for the RV32 pipeline IF stage. It is the successor to the basic PC register: a configurable reset vector and 2/4-byte sequential step for compressed fetch, and a ready handshake toward instruction memory. It adds a sticky halt state and a circular return-address stack (RAS) that predicts return targets. It feeds imem address and IF/ID pc, and takes redirects from EXE and predictions from the IF predictor.

Parameters:
ADDR_W, 15, pc/address width in bits; all pc arithmetic is modulo 2^ADDR_W.
RESET_PC, 0, pc value loaded on reset (ADDR_W bits).
RAS_DEPTH, 4, RAS entries; power of two, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
hcf  in  1  halt request; sticky once seen.
stall  in  1  pipeline hazard stall; hold pc.
pc_sel  in  2  0=sequential, 1=IF predicted target, 2=EXE pc+4, 3=EXE target.
predict_target_pc  in  ADDR_W  IF predictor target.
exe_pc  in  ADDR_W  pc of the instruction in EXE.
exe_target_pc  in  ADDR_W  resolved EXE target.
if_rvc  in  1  current fetch is 16-bit; step 2 instead of 4.
if_call  in  1  current fetch is a call; push return address.
if_ret  in  1  current fetch is a return; use RAS top.
ras_clear  in  1  synchronous RAS flush.
imem_ready  in  1  instruction memory accepts the request this cycle.
pc  out  ADDR_W  current fetch pc, registered.
imem_req_valid  out  1  fetch request valid; equals ~halted.
pc_src  out  2  how pc was formed: 0=sequential, 1=predictor, 2=RAS, 3=EXE redirect; registered with pc.
halted  out  1  sticky halt flag.
ras_empty  out  1  ras_count == 0.
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (async): pc=RESET_PC, pc_src=0, halted=0, ras_count=0, RAS pointer=0, RAS contents don't-care. imem_req_valid=1 after reset deassertion.
- step = if_rvc ? 2 : 4. seq = pc + step. exe_seq = exe_pc + 4. Carries drop at the ADDR_W wrap.
- The fetch is accepted when imem_req_valid & imem_ready & ~stall & (pc_sel is 0 or 1).
- pc_next priority, highest first:
  - halted or hcf: hold. Set halted the same edge; halted clears only on rst.
  - pc_sel=3: exe_target_pc, src 3.
  - pc_sel=2: exe_seq, src 3. EXE redirects override stall and imem_ready.
  - stall or ~imem_ready: hold pc and pc_src.
  - pc_sel=1: predict_target_pc, src 1.
  - if_ret & ~ras_empty: RAS top, src 2.
  - Otherwise: seq, src 0. This includes if_ret with an empty RAS.
- Latency: every pc update takes one cycle. No combinational path from inputs to pc.
- RAS updates only on an accepted fetch, and only when not halted:
  - call only: write seq at ptr, ptr+1 (wraps), count = min(count+1, RAS_DEPTH). Overflow overwrites the oldest entry.
  - ret only with count>0: ptr-1, count-1. Ret when empty: no change.
  - call and ret together: overwrite top with seq; ptr and count unchanged. If empty, behave as a push.
- ras_clear: count=0, ptr=0 next edge. It takes precedence over push/pop in the same cycle.
- EXE redirect does not repair the RAS. The flush path asserts ras_clear when required.
- hcf together with an EXE redirect: the halt wins and pc holds.

Test Plan:
- Reset with RESET_PC=0x100 and imem_ready=1, pc_sel=0, if_rvc alternating 0,1 -> pc 0x100, 0x104, 0x106, 0x10A; pc_src=0; imem_req_valid=1.
- At pc=0x200, stall=1 for 3 cycles then pc_sel=3 with exe_target_pc=0x40 while stall=1 -> pc holds 0x200 for 3 cycles, then 0x40 next edge with pc_src=3.
- Call at 0x10 (if_rvc=0), then call at 0x80 (if_rvc=1) -> ras_count=2. Ret fetch -> pc=0x82, src 2. Second ret -> pc=0x14. Third ret -> pc=sequential, ras_empty=1.
- RAS_DEPTH=4, 5 calls pushing A..E -> ras_count stays 4. Pops return E, D, C, B, then empty; A is lost.
- Near the wrap, pc=0x7FFE with ADDR_W=15 and if_rvc=0 -> pc=0x0002. Async rst mid-stream -> pc=RESET_PC immediately, ras_count=0.
- hcf pulse at pc=0x30 with pc_sel=3 the same cycle -> pc frozen at 0x30, halted=1, imem_req_valid=0 indefinitely, and RAS unchanged on later calls. rst clears halted.
